// File: rtl/audio_sample_cache.sv
// Per-channel 8-word line cache between the mixer sample port and SDRAM burst reads; hits answer one cycle after the request edge.
// A miss holds sdram_request until sdram_ready, then refills the whole line; incomplete bursts are re-requested.
module audio_sample_cache #(
  parameter int NUM_CHANNELS = 8,
  parameter int BURST_WORDS  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        invalidate,
  input  logic [2:0]  current_channel,
  input  logic        mem_request,
  input  logic [25:0] mem_address,
  output logic        mem_valid,
  output logic [15:0] mem_data,
  output logic        sdram_request,
  input  logic        sdram_ready,
  output logic [25:0] sdram_address,
  input  logic        sdram_rvalid,
  input  logic [25:0] sdram_raddress,
  input  logic [31:0] sdram_rdata,
  input  logic        sdram_complete
);

  typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

  typedef struct packed {
    logic [2:0]  ch;
    logic [2:0]  word;
    logic        half;
    logic [20:0] tag;
  } pend_t;

  state_t state, state_nx;
  pend_t  pend;
  logic   prev_req;
  logic   inval_pend;

  logic [NUM_CHANNELS-1:0] line_valid;
  logic [20:0]             line_tag  [NUM_CHANNELS];
  logic [BURST_WORDS-1:0]  line_mask [NUM_CHANNELS];
  logic [31:0]             line_data [NUM_CHANNELS][BURST_WORDS];

  logic                   req_edge;
  logic [20:0]            req_tag;
  logic                   hit;
  logic                   beat_ok;
  logic [BURST_WORDS-1:0] beat_bit;
  logic [BURST_WORDS-1:0] mask_now;
  logic                   fill_full;
  logic [31:0]            sel_word;
  logic                   addr_unused;

  assign addr_unused = ^{mem_address[25], sdram_raddress[1:0]};

  assign req_edge  = mem_request & ~prev_req;
  assign req_tag   = mem_address[24:4];
  // A hit edge coincident with invalidate must refill.
  assign hit       = line_valid[current_channel] && (line_tag[current_channel] == req_tag) && !invalidate;
  assign beat_ok   = (state == FILL) && sdram_rvalid && (sdram_raddress[25:5] == pend.tag);
  assign beat_bit  = {{(BURST_WORDS-1){1'b0}}, 1'b1} << sdram_raddress[4:2];
  assign mask_now  = line_mask[pend.ch] | (beat_ok ? beat_bit : '0);
  assign fill_full = &mask_now;
  assign sel_word  = line_data[pend.ch][pend.word];

  always_comb begin
    state_nx      = state;
    sdram_request = 1'b0;
    mem_valid     = 1'b0;
    mem_data      = '0;
    case (state)
      IDLE: if (req_edge) state_nx = hit ? RESP : REQ;
      REQ: begin
        sdram_request = 1'b1;
        if (sdram_ready) state_nx = FILL;
      end
      FILL: if (sdram_complete) state_nx = fill_full ? RESP : REQ;
      RESP: begin
        mem_valid = 1'b1;
        mem_data  = pend.half ? sel_word[31:16] : sel_word[15:0];
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      prev_req      <= 1'b0;
      pend          <= '0;
      inval_pend    <= 1'b0;
      sdram_address <= '0;
      line_valid    <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        line_mask[i] <= '0;
        line_tag[i]  <= '0;
      end
    end else begin
      state    <= state_nx;
      prev_req <= mem_request;
      if (invalidate) line_valid <= '0;
      case (state)
        IDLE: begin
          if (req_edge) begin
            pend.ch   <= current_channel;
            pend.word <= mem_address[3:1];
            pend.half <= mem_address[0];
            if (!hit) begin
              pend.tag                    <= req_tag;
              line_valid[current_channel] <= 1'b0;
              line_mask[current_channel]  <= '0;
              sdram_address               <= {req_tag, 5'b0};
              inval_pend                  <= 1'b0;
            end
          end
        end
        REQ: begin
          if (invalidate) inval_pend <= 1'b1;
        end
        FILL: begin
          if (invalidate) inval_pend <= 1'b1;
          if (sdram_complete && !fill_full) begin
            line_mask[pend.ch] <= '0;
          end else if (beat_ok) begin
            line_mask[pend.ch] <= mask_now;
          end
          // An invalidate seen anywhere during the fill leaves the line unusable.
          if (sdram_complete && fill_full) begin
            line_tag[pend.ch]   <= pend.tag;
            line_valid[pend.ch] <= !(inval_pend || invalidate);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (beat_ok) line_data[pend.ch][sdram_raddress[4:2]] <= sdram_rdata;
  end

endmodule

// File: tb/tb_audio_sample_cache.sv
// Self-checking bench for audio_sample_cache: directed scenarios plus randomized traffic against a per-channel line model.
module tb_audio_sample_cache;

  logic        clock;
  logic        reset;
  logic        invalidate;
  logic [2:0]  current_channel;
  logic        mem_request;
  logic [25:0] mem_address;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic        sdram_request;
  logic        sdram_ready;
  logic [25:0] sdram_address;
  logic        sdram_rvalid;
  logic [25:0] sdram_raddress;
  logic [31:0] sdram_rdata;
  logic        sdram_complete;

  int total = 0;
  int bad   = 0;

  bit          mvalid [8];
  logic [20:0] mtag   [8];
  logic [31:0] mdata  [8][8];

  audio_sample_cache dut (
    .clock(clock), .reset(reset), .invalidate(invalidate),
    .current_channel(current_channel), .mem_request(mem_request), .mem_address(mem_address),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .sdram_request(sdram_request), .sdram_ready(sdram_ready), .sdram_address(sdram_address),
    .sdram_rvalid(sdram_rvalid), .sdram_raddress(sdram_raddress), .sdram_rdata(sdram_rdata),
    .sdram_complete(sdram_complete)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_clear();
    for (int c = 0; c < 8; c++) mvalid[c] = 1'b0;
  endtask

  // Serve one miss: the caller is at the first negedge after the request edge.
  task automatic run_fill(input logic [25:0] addr, input logic [31:0] base,
                          input bit drop5, input bit inv_fill, input bit coincide);
    logic [25:0] ba;
    logic [20:0] tag, ftag;
    logic [31:0] wv;
    logic [15:0] exp;
    int perm [8];
    int rounds, first_i, last_i, tmp, j;
    ba     = {addr[24:0], 1'b0} & ~26'h1f;
    tag    = addr[24:4];
    ftag   = (tag == 21'h180) ? 21'h181 : 21'h180;
    rounds = drop5 ? 2 : 1;
    for (int r = 0; r < rounds; r++) begin
      total++;
      if (sdram_request !== 1'b1 || sdram_address !== ba) begin
        bad++;
        $display("FAIL burst_req: got req=%b addr=%h want req=1 addr=%h", sdram_request, sdram_address, ba);
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
      total++;
      if (sdram_request !== 1'b1 || sdram_address !== ba) begin
        bad++;
        $display("FAIL req_hold: got req=%b addr=%h want req=1 addr=%h", sdram_request, sdram_address, ba);
      end
      sdram_ready = 1'b1;
      @(negedge clock);
      sdram_ready = 1'b0;
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      first_i = (r == 0 && drop5 && perm[0] == 5) ? 1 : 0;
      last_i  = (r == 0 && drop5 && perm[7] == 5) ? 6 : 7;
      for (int i = 0; i < 8; i++) begin
        if (r == 0 && drop5 && perm[i] == 5) continue;
        if ($urandom_range(0, 3) == 0) @(negedge clock);
        sdram_rvalid   = 1'b1;
        sdram_raddress = ba + 26'(perm[i] * 4);
        sdram_rdata    = base + 32'(perm[i]);
        invalidate     = inv_fill && r == 0 && i == first_i;
        sdram_complete = coincide && i == last_i;
        @(negedge clock);
        sdram_rvalid   = 1'b0;
        invalidate     = 1'b0;
        sdram_complete = 1'b0;
      end
      if (!coincide) begin
        sdram_rvalid   = 1'b1;
        sdram_raddress = {ftag, addr[3:1], 2'b00};
        sdram_rdata    = 32'hdead_beef;
        @(negedge clock);
        sdram_rvalid   = 1'b0;
        sdram_complete = 1'b1;
        @(negedge clock);
        sdram_complete = 1'b0;
      end
    end
    wv  = base + 32'(addr[3:1]);
    exp = addr[0] ? wv[31:16] : wv[15:0];
    total++;
    if (mem_valid !== 1'b1 || mem_data !== exp) begin
      bad++;
      $display("FAIL fill_resp: got valid=%b data=%h want valid=1 data=%h", mem_valid, mem_data, exp);
    end
  endtask

  task automatic fetch(input logic [2:0] ch, input logic [25:0] addr, input logic [31:0] base,
                       input bit drop5, input bit inv_edge, input bit inv_fill, input bit coincide);
    logic [20:0] tag;
    logic [31:0] wv;
    logic [15:0] exp;
    bit hit;
    tag = addr[24:4];
    if (inv_edge) model_clear();
    hit = mvalid[ch] && mtag[ch] == tag;
    current_channel = ch;
    mem_address     = addr;
    mem_request     = 1'b1;
    invalidate      = inv_edge;
    @(negedge clock);
    invalidate = 1'b0;
    if (hit) begin
      wv  = mdata[ch][addr[3:1]];
      exp = addr[0] ? wv[31:16] : wv[15:0];
      total++;
      if (mem_valid !== 1'b1 || mem_data !== exp || sdram_request !== 1'b0) begin
        bad++;
        $display("FAIL hit_resp: got valid=%b data=%h req=%b want valid=1 data=%h req=0",
                 mem_valid, mem_data, sdram_request, exp);
      end
    end else begin
      run_fill(addr, base, drop5, inv_fill, coincide);
      if (inv_fill) model_clear();
      for (int k = 0; k < 8; k++) mdata[ch][k] = base + 32'(k);
      mtag[ch]   = tag;
      mvalid[ch] = !inv_fill;
    end
    mem_request = 1'b0;
    @(negedge clock);
    total++;
    if (mem_valid !== 1'b0) begin
      bad++;
      $display("FAIL valid_pulse: got %b want 0", mem_valid);
    end
  endtask

  task automatic pulse_invalidate();
    invalidate = 1'b1;
    @(negedge clock);
    invalidate = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b0; invalidate = 1'b0; current_channel = '0; mem_request = 1'b0; mem_address = '0;
    sdram_ready = 1'b0; sdram_rvalid = 1'b0; sdram_raddress = '0; sdram_rdata = '0; sdram_complete = 1'b0;
    model_clear();
    repeat (3) @(negedge clock);
    total++;
    if (mem_valid !== 1'b0 || mem_data !== 16'h0 || sdram_request !== 1'b0 || sdram_address !== 26'h0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b data=%h req=%b addr=%h want all zero",
               mem_valid, mem_data, sdram_request, sdram_address);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_miss_fill();
    fetch(3'd0, 26'h000100, 32'h1111_0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_hits();
    for (int a = 'h101; a <= 'h10f; a++) fetch(3'd0, 26'(a), 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_two_channels();
    fetch(3'd0, 26'h000110, 32'h2222_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    fetch(3'd1, 26'h000100, 32'h3333_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch(3'd0, 26'h000117, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch(3'd1, 26'h00010a, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_invalidate();
    fetch(3'd0, 26'h000110, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_invalidate();
    fetch(3'd0, 26'h000110, 32'h5555_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch(3'd0, 26'h000115, 32'h6666_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    fetch(3'd1, 26'h000200, 32'h7777_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    fetch(3'd1, 26'h000203, 32'h8888_0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_missing_beat();
    fetch(3'd4, 26'h003456, 32'h9999_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    fetch(3'd4, 26'h003451, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch(3'd5, 26'h003458, 32'haaaa_0000, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_fill();
    logic [25:0] addr, ba;
    logic [31:0] base;
    addr = 26'h000340;
    ba   = {addr[24:0], 1'b0} & ~26'h1f;
    base = $urandom;
    current_channel = 3'd2; mem_address = addr; mem_request = 1'b1;
    @(negedge clock);
    total++;
    if (sdram_request !== 1'b1) begin
      bad++;
      $display("FAIL rst_fill_req: got %b want 1", sdram_request);
    end
    sdram_ready = 1'b1;
    @(negedge clock);
    sdram_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sdram_rvalid = 1'b1; sdram_raddress = ba + 26'(k * 4); sdram_rdata = base + 32'(k);
      @(negedge clock);
    end
    sdram_rvalid = 1'b0; mem_request = 1'b0; reset = 1'b0;
    #1;
    total++;
    if (mem_valid !== 1'b0 || mem_data !== 16'h0 || sdram_request !== 1'b0 || sdram_address !== 26'h0) begin
      bad++;
      $display("FAIL async_reset: got valid=%b data=%h req=%b addr=%h want all zero",
               mem_valid, mem_data, sdram_request, sdram_address);
    end
    @(negedge clock);
    reset = 1'b1;
    model_clear();
    for (int k = 3; k < 8; k++) begin
      sdram_rvalid = 1'b1; sdram_raddress = ba + 26'(k * 4); sdram_rdata = base + 32'(k);
      sdram_complete = (k == 7);
      @(negedge clock);
    end
    sdram_rvalid = 1'b0; sdram_complete = 1'b0;
    @(negedge clock);
    total++;
    if (mem_valid !== 1'b0 || sdram_request !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got valid=%b req=%b want 0 0", mem_valid, sdram_request);
    end
    fetch(3'd2, addr, 32'hbbbb_0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [20:0] pool [3];
    logic [25:0] addr;
    pool[0] = 21'h000010; pool[1] = 21'h000011; pool[2] = 21'h1a5f3;
    for (int n = 0; n < 50; n++) begin
      addr = {1'($urandom_range(0, 1)), pool[$urandom_range(0, 2)],
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      if ($urandom_range(0, 11) == 0) pulse_invalidate();
      fetch(3'($urandom_range(0, 7)), addr, $urandom,
            $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hits();
    test_two_channels();
    test_invalidate();
    test_missing_beat();
    test_reset_mid_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
